music_sequencer: RTL and testbench
==================================

// Module: music_sequencer
// PURPOSE
//  Song-playback controller for the audio path. Walks a song memory of (note, duration)
//  byte pairs: note at even address, duration in ticks at odd address. Presents the
//  current note number to the wavegen/note-lookup datapath.
//  Handles start/stop/pause, tempo ticks, song looping and end-of-song detection.
//  Sits between the game-control FSM and the wavegen.
// PARAMETERS
//  CLOCK_FREQ    50_000_000  system clock frequency, Hz
//  TICK_FREQ     16          duration tick rate, Hz; TICK_DIV = CLOCK_FREQ/TICK_FREQ
//  ADDR_W        8           song memory address width (byte addressed)
//  ARTIC_CYCLES  500_000     silence length at end of each note (MUSIC_ARTICULATION_EN only)
// PORTS
//  clock      in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       pulse: (re)start song from address 0
//  stop       in   1       pulse: halt playback, output rest
//  pause      in   1       level: freeze playback and mute while high
//  loop_en    in   1       level: at end marker, wrap to address 0 instead of stopping
//  mem_rd     out  1       song memory read strobe
//  mem_addr   out  ADDR_W  song memory read address
//  mem_rdata  in   8       read data, valid the cycle after mem_rd
//  note       out  8       note number to wavegen; 0 = rest
//  playing    out  1       high in any state except IDLE
//  song_done  out  1       1-cycle pulse when end marker is reached with loop_en=0
// BEHAVIOUR
//  - Reset values: note=0, mem_rd=0, mem_addr=0, playing=0, song_done=0.
//    Internal: ptr=0, state=IDLE.
//  - States and transitions:
//    IDLE: note=0. start -> RD_NOTE with ptr=0.
//    RD_NOTE: mem_rd=1, mem_addr=ptr. -> RD_DUR.
//    RD_DUR: mem_rd=1, mem_addr=ptr+1; note_buf<=mem_rdata. -> LOAD.
//    LOAD: dur<=mem_rdata.
//      If dur==0 (end marker): with loop_en=1, ptr<=0 -> RD_NOTE;
//      otherwise song_done=1 -> IDLE.
//      Else note<=note_buf, dur_cnt<=dur, tick counter cleared -> PLAY.
//    PLAY: the tick counter counts 0..TICK_DIV-1; a tick fires at TICK_DIV-1.
//      On a tick, dur_cnt decrements.
//      On a tick with dur_cnt==1: ptr<=ptr+2 (mod 2^ADDR_W, natural wrap) -> RD_NOTE.
//  - Note-to-note gap is 3 cycles (RD_NOTE/RD_DUR/LOAD); the previous note is held
//    on `note` during the fetch.
//  - pause=1 in PLAY: tick counter and dur_cnt frozen, note output forced to 0.
//    pause=0 resumes the same note with the remaining duration.
//    Fetch states complete regardless of pause. In IDLE, pause has no effect.
//  - stop: from any state -> IDLE next cycle; ptr=0, note=0.
//  - start in any non-IDLE state restarts from ptr=0 (-> RD_NOTE).
//  - stop and start in the same cycle: stop wins.
//  - Note value 0 is a valid rest note: played for its duration, note=0.
//  - mem_rd is asserted only in RD_NOTE and RD_DUR.
//  - Reset mid-song: immediate return to reset values, asynchronous.
// CONFIGURATION
//  MUSIC_ARTICULATION_EN defined:
//    In PLAY with dur_cnt==1 and tick counter >= TICK_DIV-ARTIC_CYCLES, note is forced
//    to 0, so repeated notes are audibly separated.
//    Timing of ticks and fetches is unchanged.
//  Undefined: note is held for the full duration; back-to-back identical notes merge.
// STRUCTURE
//  music_pkg:
//    - constants: CLOCK_FREQ, NOTE_REST=8'd0, DUR_END=8'd0
//    - typedefs: note_t (logic [7:0]), enum seq_state_t
//      {IDLE, RD_NOTE, RD_DUR, LOAD, PLAY}
//  Sub-module tick_divider (clock, reset, clear, enable -> tick, count):
//    - parameterized by TICK_DIV
//    - count exported for the articulation compare
// TESTING (bench overrides CLOCK_FREQ=100, TICK_FREQ=10 -> TICK_DIV=10;
//          ARTIC_CYCLES=3)
//  1. Memory {8'd40,8'd2, 8'd44,8'd1, 8'd0,8'd0}, pulse start, loop_en=0
//     -> note=40 for 20 cycles, then 44 for 10 cycles.
//     -> song_done pulses once; note=0; playing=0.
//  2. Same memory with loop_en=1
//     -> sequence 40,44,40,44... with no song_done.
//     -> mem_addr returns to 0 after reading address 5.
//  3. pause=1 for 15 cycles midway through the note-40 duration
//     -> note=0 while paused; on release, note=40 for the remaining cycles.
//     -> total note-40 cycles still 20.
//  4. stop and start asserted in the same cycle during PLAY
//     -> IDLE next cycle, note=0.
//     -> A later start re-fetches from address 0 (mem_addr=0, then 1).
//  5. Song fills memory without an end marker (ADDR_W=4), loop_en=0
//     -> ptr wraps 14 -> 0.
//     -> playback continues from the first note.
//  6. With MUSIC_ARTICULATION_EN, memory {40,1, 40,1, 0,0}
//     -> note=40 for 7 cycles, 0 for 3 cycles, then 40 again after the 3-cycle fetch.
//     -> Assert async reset mid-note: note=0 immediately.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the song-playback sequencer.
package music_pkg;

  localparam int CLOCK_FREQ = 50_000_000;

  localparam logic [7:0] NOTE_REST = 8'd0;
  localparam logic [7:0] DUR_END   = 8'd0;

  typedef logic [7:0] note_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_NOTE,
    RD_DUR,
    LOAD,
    PLAY
  } seq_state_t;

  // Clock cycles per duration tick, never less than one.
  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    int div;
    div = clk_hz / tick_hz;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/music_sequencer_tick_divider.sv
// Free-running tempo divider: counts 0..TICK_DIV-1 while enabled and
// fires a single-cycle tick on the last count. The count is exported so
// the sequencer can tell how far into a tick period it is.
module tick_divider #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tick  = i_enable && (r_count == LAST);
  assign o_count = r_count;

  // Advance the period counter; clear has priority and holds it at zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Song-playback controller. Walks (note, duration) byte pairs from song
// memory and presents the current note to the wavegen; 0 means rest.
// Optional feature macro: MUSIC_ARTICULATION_EN -- when defined, the last
// ARTIC_CYCLES of every note are silenced (and stay silent through the
// following fetch) so repeated notes do not merge.
//
// state   | meaning
// IDLE    | stopped, note output is rest
// RD_NOTE | read strobe on the note byte at ptr
// RD_DUR  | read strobe on the duration byte at ptr+1, capture note
// LOAD    | inspect duration: end marker or start a new note
// PLAY    | note sounding, duration counted down on tempo ticks
module music_sequencer
  import music_pkg::*;
#(
  parameter int CLOCK_FREQ   = music_pkg::CLOCK_FREQ,
  parameter int TICK_FREQ    = 16,
`ifdef MUSIC_ARTICULATION_EN
  parameter int ARTIC_CYCLES = 500_000,
`endif
  parameter int ADDR_W       = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_loop_en,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_note,
  output logic              o_playing,
  output logic              o_song_done
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_FREQ, TICK_FREQ);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef MUSIC_ARTICULATION_EN
  localparam bit ARTIC_EN    = 1'b1;
  localparam int ARTIC_START = (ARTIC_CYCLES >= TICK_DIV) ? 0 : TICK_DIV - ARTIC_CYCLES;
`else
  // Start of the silent window sits past the last count, so it never opens.
  localparam bit ARTIC_EN    = 1'b0;
  localparam int ARTIC_START = TICK_DIV;
`endif

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  note_t             r_note_buf;
  note_t             r_note;
  logic [7:0]        r_dur_cnt;

  logic              w_tick;
  logic              w_clear;
  logic              w_enable;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              w_artic_zone;
  logic              w_mute;

  assign w_clear      = (r_state != PLAY);
  assign w_enable     = (r_state == PLAY) && !i_pause;
  assign w_ptr_next   = r_ptr + ADDR_W'(2);
  assign w_artic_zone = ARTIC_EN && (r_dur_cnt == 8'd1) && (int'(w_count) >= ARTIC_START);

  // Pause mutes immediately; the held note comes back unchanged on release.
  assign w_mute = (r_state == PLAY) && (i_pause || w_artic_zone);
  assign o_note = w_mute ? NOTE_REST : r_note;

  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_divider (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_tick   (w_tick),
    .o_count  (w_count)
  );

  // Sequencer FSM with registered memory strobe, address and status outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_note_buf  <= NOTE_REST;
      r_note      <= NOTE_REST;
      r_dur_cnt   <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_addr  <= '0;
      o_playing   <= 1'b0;
      o_song_done <= 1'b0;
    end else begin
      o_song_done <= 1'b0;
      if (i_stop) begin
        r_state    <= IDLE;
        r_ptr      <= '0;
        r_note     <= NOTE_REST;
        o_mem_rd   <= 1'b0;
        o_mem_addr <= '0;
        o_playing  <= 1'b0;
      end else if (i_start) begin
        r_state    <= RD_NOTE;
        r_ptr      <= '0;
        o_mem_rd   <= 1'b1;
        o_mem_addr <= '0;
        o_playing  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_note <= NOTE_REST;
          end
          RD_NOTE: begin
            o_mem_addr <= r_ptr + ADDR_W'(1);
            r_state    <= RD_DUR;
          end
          RD_DUR: begin
            r_note_buf <= i_mem_rdata;
            o_mem_rd   <= 1'b0;
            r_state    <= LOAD;
          end
          LOAD: begin
            if (i_mem_rdata == DUR_END) begin
              if (i_loop_en) begin
                r_ptr      <= '0;
                o_mem_rd   <= 1'b1;
                o_mem_addr <= '0;
                r_state    <= RD_NOTE;
              end else begin
                o_song_done <= 1'b1;
                r_note      <= NOTE_REST;
                o_playing   <= 1'b0;
                r_state     <= IDLE;
              end
            end else begin
              r_note    <= r_note_buf;
              r_dur_cnt <= i_mem_rdata;
              r_state   <= PLAY;
            end
          end
          PLAY: begin
            if (w_tick) begin
              r_dur_cnt <= r_dur_cnt - 8'd1;
              if (r_dur_cnt == 8'd1) begin
                r_ptr      <= w_ptr_next;
                o_mem_rd   <= 1'b1;
                o_mem_addr <= w_ptr_next;
                r_state    <= RD_NOTE;
                // Keep the articulation gap silent through the next fetch.
                if (ARTIC_EN) r_note <= NOTE_REST;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: TICK_DIV=10, ADDR_W=4, synchronous
// song memory with one-cycle read latency. Expectations for both builds of
// MUSIC_ARTICULATION_EN are written out by hand.
module tb_music_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_en = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'd0;
  logic [7:0]    note;
  logic          playing;
  logic          song_done;

  logic [7:0]    mem [16];
  logic [AW-1:0] rd_log [$];
  int            exp_addr [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
  int            n_vec = 0;
  int            n_miss = 0;
  int            n_done = 0;

  music_sequencer #(
    .CLOCK_FREQ   (100),
    .TICK_FREQ    (10),
`ifdef MUSIC_ARTICULATION_EN
    .ARTIC_CYCLES (3),
`endif
    .ADDR_W       (AW)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_pause     (pause),
    .i_loop_en   (loop_en),
    .o_mem_rd    (mem_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_note      (note),
    .o_playing   (playing),
    .o_song_done (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (song_done) n_done++;
    if (mem_rd) rd_log.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_note(input string tag, input logic [7:0] val, input int bound);
    int n = 0;
    while (note !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, note, val);
  endtask

  // Length of the run of `val` starting at the current sample.
  task automatic seg(input string tag, input logic [7:0] val, input int len);
    int n = 0;
    while (note === val && n < len + 8) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, len);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (playing !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, playing, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
  endtask

  initial begin
    int n40;
    int n0;

    clear_mem();
    cyc(2);
    chk("rst_note", note, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_playing", playing, 0);
    chk("rst_song_done", song_done, 0);
    rst = 1'b0;
    cyc(2);

    // 1: single pass, end marker stops the song
    mem[0] = 8'd40; mem[1] = 8'd2; mem[2] = 8'd44; mem[3] = 8'd1;
    pulse_start();
    chk("t1_playing", playing, 1);
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_addr0", mem_addr, 0);
    wait_note("t1_first", 8'd40, 10);
`ifdef MUSIC_ARTICULATION_EN
    seg("t1_len40", 8'd40, 17);
    seg("t1_gap", 8'd0, 6);
    seg("t1_len44", 8'd44, 7);
`else
    seg("t1_len40", 8'd40, 23);
    seg("t1_len44", 8'd44, 13);
`endif
    wait_idle("t1_idle", 20);
    chk("t1_done_pulse", song_done, 1);
    chk("t1_note_rest", note, 0);
    @(negedge clk);
    chk("t1_done_clear", song_done, 0);
    cyc(3);
    chk("t1_done_count", n_done, 1);

    // 2: looping, no song_done, address wraps to 0 after 5
    loop_en = 1'b1;
    rd_log.delete();
    pulse_start();
    wait_note("t2_first", 8'd40, 10);
`ifdef MUSIC_ARTICULATION_EN
    seg("t2_len40a", 8'd40, 17);
    seg("t2_gap_a", 8'd0, 6);
    seg("t2_len44", 8'd44, 7);
    seg("t2_gap_loop", 8'd0, 9);
    seg("t2_len40b", 8'd40, 17);
`else
    seg("t2_len40a", 8'd40, 23);
    seg("t2_len44", 8'd44, 16);
    seg("t2_len40b", 8'd40, 23);
`endif
    chk("t2_rdlog_len", rd_log.size() >= 8, 1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_rdaddr%0d", i), (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFF, exp_addr[i]);
    chk("t2_no_done", n_done, 1);
    pulse_stop();
    chk("t2_stop_idle", playing, 0);
    loop_en = 1'b0;

    // 3: pause midway through note 40
    pulse_start();
    wait_note("t3_first", 8'd40, 10);
    n40 = 0;
    for (int i = 0; i < 5; i++) begin
      if (note === 8'd40) n40++;
      @(negedge clk);
    end
    chk("t3_pre_pause", n40, 5);
    pause = 1'b1;
    n0 = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (note === 8'd0 && playing === 1'b1) n0++;
      @(negedge clk);
    end
    chk("t3_muted", n0, 15);
    pause = 1'b0;
    #1;
`ifdef MUSIC_ARTICULATION_EN
    seg("t3_resume", 8'd40, 12);
`else
    seg("t3_resume", 8'd40, 18);
`endif
    pulse_stop();
    chk("t3_stop_note", note, 0);

    // 4: stop and start together -> stop wins
    pulse_start();
    wait_note("t4_first", 8'd40, 10);
    cyc(3);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    chk("t4_playing", playing, 0);
    chk("t4_note", note, 0);
    chk("t4_mem_rd", mem_rd, 0);
    cyc(3);
    chk("t4_still_idle", playing, 0);
    pulse_start();
    chk("t4_re_rd", mem_rd, 1);
    chk("t4_re_addr0", mem_addr, 0);
    @(negedge clk);
    chk("t4_re_addr1", mem_addr, 1);
    pulse_stop();

    // 5: no end marker, pointer wraps 14 -> 0; note 0 at slot 3 is a rest
    for (int k = 0; k < 8; k++) begin
      mem[2*k]   = 8'(10 + k);
      mem[2*k+1] = 8'd1;
    end
    mem[6] = 8'd0;
    pulse_start();
    wait_note("t5_first", 8'd10, 10);
`ifdef MUSIC_ARTICULATION_EN
    for (int k = 0; k < 9; k++) begin
      if (k != 3) begin
        seg($sformatf("t5_note%0d", k), 8'(10 + (k % 8)), 7);
        if (k < 8) seg($sformatf("t5_gap%0d", k), 8'd0, (k == 2) ? 19 : 6);
      end
    end
`else
    for (int k = 0; k < 9; k++)
      seg($sformatf("t5_note%0d", k), (k == 3) ? 8'd0 : 8'(10 + (k % 8)), 13);
`endif
    pulse_stop();

    // 6: repeated note, articulation gap, then async reset mid-note
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd1; mem[2] = 8'd40; mem[3] = 8'd1;
    pulse_start();
    wait_note("t6_first", 8'd40, 10);
`ifdef MUSIC_ARTICULATION_EN
    seg("t6_len40a", 8'd40, 7);
    seg("t6_gap", 8'd0, 6);
    seg("t6_len40b", 8'd40, 7);
`else
    seg("t6_merged", 8'd40, 26);
`endif
    wait_idle("t6_idle", 20);
    pulse_start();
    wait_note("t6_again", 8'd40, 10);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("t6_rst_note", note, 0);
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_mem_rd", mem_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    chk("t6_post_rst_idle", playing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
